pwm_output_stage: RTL and testbench
===================================

# pwm_output_stage

Drives the 16 user output pins from the SPI-programmed control registers. It consumes the five registers held by the SPI register block: output enables, PWM-mode enables and the shared 8-bit duty cycle. It generates one shared PWM waveform and produces a registered 16-bit output bus. Duty changes are double-buffered so that every PWM period is glitch-free.

## Interface
Parameters:
- PRESCALE, default 1: clk cycles per PWM counter step; legal range 1..65535; PWM period = 255 × PRESCALE clk cycles.

Ports:
- clk  input  1  system clock; the block's only clock.
- rst  input  1  synchronous, active-high reset, sampled on rising clk.
- en_reg_out_7_0  input  8  output enable, pins 7..0.
- en_reg_out_15_8  input  8  output enable, pins 15..8.
- en_reg_pwm_7_0  input  8  PWM-mode select, pins 7..0.
- en_reg_pwm_15_8  input  8  PWM-mode select, pins 15..8.
- pwm_duty_cycle  input  8  requested duty; 0 = always low, 255 = always high.
- out  output  16  registered pin drive; bit i = pin i.
- period_start  output  1  one-cycle pulse, registered, high in the cycle the PWM counter reads 0 after a step.

## Operation
- Prescaler: pre_cnt counts 0..PRESCALE-1 and then wraps to 0.
  - Step strobe: step = (pre_cnt == PRESCALE-1).
  - When PRESCALE = 1, step is high every cycle.
- PWM counter: pwm_cnt is 8 bits and counts 0..254.
  - On step it increments.
  - On step with pwm_cnt == 254 it wraps to 0. It never holds 255.
- Duty shadow: duty_sh is 8 bits.
  - It loads pwm_duty_cycle on the step that wraps pwm_cnt 254→0.
  - It holds at all other times.
  - Changes mid-period therefore take effect at the next period boundary only.
- PWM level: pwm = (pwm_cnt < duty_sh), unsigned 8-bit compare.
  - duty_sh = 0 gives constant 0.
  - duty_sh = 255 gives constant 1, because 255 > every reachable count.
  - Otherwise high for duty_sh of every 255 steps.
- Per pin i, with en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0}:
  - en_out[i] = 0: out[i] = 0, regardless of en_pwm.
  - en_out[i] = 1, en_pwm[i] = 0: out[i] = 1, static.
  - en_out[i] = 1, en_pwm[i] = 1: out[i] = pwm.
- Enable bits are not shadowed. A change is visible on out one cycle later, even mid-period.
- All 16 PWM pins share one counter and one duty, so they switch in phase.
- Reset (rst high at a clk edge), from any state, in that same edge:
  - pre_cnt = 0, pwm_cnt = 0, duty_sh = 0.
  - out = 16'h0000, period_start = 0.
  - rst held high keeps every register at these values.
- First period after reset:
  - Runs with duty_sh = 0, so PWM pins are low.
  - The programmed duty is first applied at the first 254→0 wrap.

## Timing
- out and period_start are flops. out[i] at edge n+1 reflects the inputs and the pwm_cnt/duty_sh values present before edge n+1. That is one cycle of latency from any input change.
- First rising clk edge with rst low:
  - pre_cnt advances.
  - With PRESCALE = 1, pwm_cnt goes 0→1.
  - out reflects pwm_cnt = 0, duty_sh = 0.
- period_start rises in the cycle after the edge on which pwm_cnt wraps to 0. It lasts exactly 1 cycle, even when PRESCALE > 1.
- Boundary cases:
  - pwm_duty_cycle changes in the same cycle as the wrap step: the new value is captured.
  - rst asserted in the same cycle as the wrap: reset wins, and duty_sh = 0.
- No handshakes. Inputs are level-sampled every cycle and are required to be synchronous to clk, which holds when the SPI register block runs on the same clk.

## Test plan
- Reset: hold rst for 3 cycles with all inputs 8'hFF → out = 16'h0000, period_start = 0 throughout. After release, out = 16'h0000 for the first 255 × PRESCALE cycles.
- Duty 128, PRESCALE = 1, en_out = en_pwm = 16'hFFFF, measured after the first boundary → every pin high for exactly 128 and low for 127 cycles per 255-cycle period. period_start pulses every 255 cycles.
- Duty extremes, steady state → duty 0 gives PWM pins constant 0; duty 255 gives constant 1, with no single-cycle glitch at wrap.
- Static and disabled modes: en_out = 16'h00F0, en_pwm = 16'h0030, duty 64 → out[7:6] = 1 constant, out[5:4] = PWM, all other bits 0.
- Mid-period duty change: duty 50→200 written at pwm_cnt = 100 → the current period stays at 50 high cycles, the next period has 200, and the switch is aligned to period_start.
- Reset mid-operation and prescaler: PRESCALE = 4, duty 10, rst pulsed for 1 cycle at pwm_cnt = 77 → the next cycle shows out = 0 and the counters restart. High time is 40 clk per 1020-clk period after the next boundary.

Source files
------------

// File: rtl/pwm_output_stage_if.sv
// Register-side bundle for the PWM output stage: enable/duty levels in,
// registered pin drive and period marker out.
interface pwm_output_stage_if;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  // Register block side: drives the control levels, observes the pins.
  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
    output pwm_duty_cycle,
    input  out, period_start
  );

  // Output stage side.
  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
    input  pwm_duty_cycle,
    output out, period_start
  );
endinterface

// File: rtl/pwm_output_stage.sv
// PWM output stage: one shared prescaled 0..254 counter, a double-buffered
// duty compare, and a per-pin mux selecting off / static high / PWM.

// Per-pin drive select; combinational, the top registers the whole bus.
module pwm_pin_lane (
  input  logic en_out,
  input  logic en_pwm,
  input  logic pwm,
  output logic drive
);
  // Disabled pins are low; enabled pins are high unless PWM mode picks the wave.
  always_comb begin
    drive = en_out & (~en_pwm | pwm);
  end
endmodule

module pwm_output_stage #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic                clk,
  input  logic                rst,
  pwm_output_stage_if.slave   bus
);
  localparam int unsigned NUM_LANES = 16;
  localparam logic [15:0] PRE_LAST  = 16'(PRESCALE - 1);
  localparam logic [7:0]  CNT_LAST  = 8'd254;

  logic [15:0] pre_cnt_q, pre_cnt_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [7:0]  duty_sh_q, duty_sh_d;
  logic [NUM_LANES-1:0] out_q, out_d;
  logic        period_start_q, period_start_d;

  logic        step;
  logic        wrap;
  logic        pwm;
  logic [NUM_LANES-1:0] en_out;
  logic [NUM_LANES-1:0] en_pwm;
  logic [NUM_LANES-1:0] lane_drive;

  // Flatten the byte-wide enable registers into per-pin vectors.
  always_comb begin
    en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
  end

  // Prescaler, period counter and duty shadow next-state. The shadow only
  // reloads on the 254->0 wrap so a period never sees a partial duty.
  always_comb begin
    step      = (pre_cnt_q == PRE_LAST);
    wrap      = step && (pwm_cnt_q == CNT_LAST);
    pre_cnt_d = step ? 16'd0 : pre_cnt_q + 16'd1;
    pwm_cnt_d = pwm_cnt_q;
    if (step) pwm_cnt_d = wrap ? 8'd0 : pwm_cnt_q + 8'd1;
    duty_sh_d = wrap ? bus.pwm_duty_cycle : duty_sh_q;
    // The counter never reaches 255, so duty 255 is a solid high.
    pwm       = (pwm_cnt_q < duty_sh_q);
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      pwm_pin_lane u_lane (
        .en_out (en_out[gi]),
        .en_pwm (en_pwm[gi]),
        .pwm    (pwm),
        .drive  (lane_drive[gi])
      );
    end
  endgenerate

  // Output bus and period marker next-state; enables act on the next edge.
  always_comb begin
    out_d          = lane_drive;
    period_start_d = wrap;
  end

  // State registers; reset overrides a coincident wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q      <= '0;
      pwm_cnt_q      <= '0;
      duty_sh_q      <= '0;
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      duty_sh_q      <= duty_sh_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign bus.out          = out_q;
  assign bus.period_start = period_start_q;
endmodule

// File: tb/tb_pwm_output_stage.sv
// Bench for pwm_output_stage: two instances (PRESCALE 1 and 4) share inputs
// and are checked every cycle against a time-based model, plus directed
// high-time measurements per period.
module tb_pwm_output_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] en_out, en_pwm;
  logic [7:0]  duty;

  pwm_output_stage_if if1();
  pwm_output_stage_if if4();

  assign if1.en_reg_out_7_0  = en_out[7:0];
  assign if1.en_reg_out_15_8 = en_out[15:8];
  assign if1.en_reg_pwm_7_0  = en_pwm[7:0];
  assign if1.en_reg_pwm_15_8 = en_pwm[15:8];
  assign if1.pwm_duty_cycle  = duty;
  assign if4.en_reg_out_7_0  = en_out[7:0];
  assign if4.en_reg_out_15_8 = en_out[15:8];
  assign if4.en_reg_pwm_7_0  = en_pwm[7:0];
  assign if4.en_reg_pwm_15_8 = en_pwm[15:8];
  assign if4.pwm_duty_cycle  = duty;

  pwm_output_stage #(.PRESCALE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  pwm_output_stage #(.PRESCALE(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: elapsed clk edges since reset and the duty latched at the last boundary.
  int          e   [2];
  logic [7:0]  md  [2];
  int          pr  [2] = '{1, 4};
  logic [15:0] xo  [2];
  logic        xp  [2];

  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      int   cnt;
      logic pw;
      if (rst) begin
        xo[d] = '0; xp[d] = 1'b0; e[d] = 0; md[d] = '0;
      end else begin
        cnt   = (e[d] / pr[d]) % 255;
        pw    = (cnt < int'(md[d]));
        xo[d] = en_out & (~en_pwm | {16{pw}});
        xp[d] = ((e[d] % (255 * pr[d])) == (255 * pr[d] - 1));
        if (xp[d]) md[d] = duty;
        e[d]++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_p1", {16'h0, if1.out}, {16'h0, xo[0]});
    chk("ps_p1",  {31'h0, if1.period_start}, {31'h0, xp[0]});
    chk("out_p4", {16'h0, if4.out}, {16'h0, xo[1]});
    chk("ps_p4",  {31'h0, if4.period_start}, {31'h0, xp[1]});
  endtask

  function automatic logic ps_of(input int d);
    return (d == 0) ? if1.period_start : if4.period_start;
  endfunction

  function automatic logic bit_of(input int d, input int b);
    return (d == 0) ? if1.out[b] : if4.out[b];
  endfunction

  task automatic wait_ps(input int d);
    bit seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      tick();
      if (ps_of(d)) seen = 1'b1;
    end
    if (!seen) chk("ps_timeout", 32'd0, 32'd1);
  endtask

  task automatic measure(input int d, input int b, input int n, output int hi, output logic ps_last);
    hi = 0;
    ps_last = 1'b0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (bit_of(d, b)) hi++;
      ps_last = ps_of(d);
    end
  endtask

  int   hi, hi_a, nz;
  logic psl;

  initial begin
    en_out = 16'hFFFF; en_pwm = 16'hFFFF; duty = 8'hFF; rst = 1'b1;
    @(negedge clk);
    repeat (3) tick();
    chk("rst_out", {16'h0, if1.out}, 32'h0);
    chk("rst_ps",  {31'h0, if1.period_start}, 32'h0);
    rst = 1'b0;

    // First period after reset runs at duty 0 on both prescalers.
    nz = 0;
    for (int k = 0; k < 255; k++) begin
      tick();
      if (if1.out != 16'h0) nz++;
    end
    chk("first_period_zero", nz, 0);

    duty = 8'd128;
    wait_ps(0);
    measure(0, 0, 255, hi, psl);
    chk("duty128_hi", hi, 128);
    chk("duty128_ps_interval", {31'h0, psl}, 32'h1);
    measure(0, 9, 255, hi, psl);
    chk("duty128_hi_pin9", hi, 128);

    duty = 8'd0;
    wait_ps(0);
    measure(0, 3, 255, hi, psl);
    chk("duty0_hi", hi, 0);

    duty = 8'd255;
    wait_ps(0);
    measure(0, 15, 255, hi, psl);
    chk("duty255_hi", hi, 255);

    en_out = 16'h00F0; en_pwm = 16'h0030; duty = 8'd64;
    wait_ps(0);
    measure(0, 4, 255, hi, psl);
    chk("mixed_pwm_hi", hi, 64);
    measure(0, 7, 255, hi, psl);
    chk("mixed_static_hi", hi, 255);
    measure(0, 8, 255, hi, psl);
    chk("mixed_off_hi", hi, 0);

    // Mid-period duty change takes effect only at the next boundary.
    en_out = 16'hFFFF; en_pwm = 16'hFFFF; duty = 8'd50;
    wait_ps(0);
    measure(0, 0, 100, hi_a, psl);
    duty = 8'd200;
    measure(0, 0, 155, hi, psl);
    chk("midchange_cur", hi_a + hi, 50);
    chk("midchange_ps_align", {31'h0, psl}, 32'h1);
    measure(0, 0, 255, hi, psl);
    chk("midchange_next", hi, 200);

    // Prescaler 4 with a reset pulse at count 77.
    duty = 8'd10;
    wait_ps(1);
    for (int k = 0; k < 1100 && ((e[1] / 4) % 255) != 77; k++) tick();
    chk("reach_cnt77", (e[1] / 4) % 255, 77);
    rst = 1'b1;
    tick();
    chk("midrst_out4", {16'h0, if4.out}, 32'h0);
    rst = 1'b0;
    measure(1, 0, 1020, hi, psl);
    chk("p4_first_hi", hi, 0);
    chk("p4_first_ps", {31'h0, psl}, 32'h1);
    measure(1, 0, 1020, hi, psl);
    chk("p4_duty10_hi", hi, 40);
    chk("p4_ps_interval", {31'h0, psl}, 32'h1);

    // Random traffic, including rare resets, against the cycle model.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 49) == 0) en_out = 16'($urandom);
      if ($urandom_range(0, 49) == 0) en_pwm = 16'($urandom);
      if ($urandom_range(0, 99) == 0) duty   = 8'($urandom);
      rst = ($urandom_range(0, 1499) == 0);
      tick();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
